// File: rtl/axi_pack_index_unpack.sv
// Turns a stream of packed index beats (AXI R) into element addresses
// base + (index << elem_size), one address per cycle.
module axi_pack_index_unpack #(
  parameter int unsigned AddrWidth  = 48,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned AxiIdWidth = 4,
  parameter logic [AxiIdWidth-1:0] IndexId = '1,
  localparam int unsigned OffW = $clog2(DataWidth/8)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [AddrWidth-1:0]  cfg_base_i,
  input  logic [1:0]            cfg_idx_size_i,
  input  logic [2:0]            cfg_elem_size_i,
  input  logic [15:0]           cfg_num_i,
  input  logic [OffW-1:0]       cfg_offset_i,
  input  logic                  r_valid_i,
  output logic                  r_ready_o,
  input  logic [DataWidth-1:0]  r_data_i,
  input  logic [AxiIdWidth-1:0] r_id_i,
  input  logic                  r_last_i,
  output logic                  addr_valid_o,
  input  logic                  addr_ready_i,
  output logic [AddrWidth-1:0]  addr_o,
  output logic                  addr_last_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int unsigned SW = OffW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  state_e state_q, state_d;

  logic [AddrWidth-1:0] base_q;
  logic [1:0]           idx_size_q;
  logic [2:0]           elem_size_q;
  logic [15:0]          remaining_q;
  logic [OffW-1:0]      lane_q;
  logic                 buf_valid_q, buf_last_q;
  logic [DataWidth-1:0] buf_data_q;
  logic                 err_q;

  logic                 cfg_hs, r_hs, a_hs;
  logic [SW-1:0]        lane_nxt;
  logic                 final_lane, early_last;
  logic [DataWidth-1:0] lane_data;
  logic [63:0]          idx64;
  logic [AddrWidth-1:0] idx_addr;

  // Carry out of the lane pointer marks the last index of the beat.
  assign lane_nxt   = {1'b0, lane_q} + (SW'(1) << idx_size_q);
  assign final_lane = lane_nxt[OffW];
  assign lane_data  = buf_data_q >> {lane_q, 3'b000};

  always_comb begin
    idx64 = '0;
    case (idx_size_q)
      2'd0:    idx64 = 64'(lane_data[7:0]);
      2'd1:    idx64 = 64'(lane_data[15:0]);
      2'd2:    idx64 = 64'(lane_data[31:0]);
      default: idx64 = lane_data[63:0];
    endcase
  end

  assign idx_addr    = AddrWidth'(idx64);
  assign addr_o      = base_q + (idx_addr << elem_size_q);
  assign addr_last_o = (remaining_q == '0) | (final_lane & buf_last_q);
  assign early_last  = final_lane & buf_last_q & (remaining_q != '0);

  assign cfg_hs = cfg_valid_i & cfg_ready_o;
  assign r_hs   = r_valid_i & r_ready_o;
  assign a_hs   = addr_valid_o & addr_ready_i;
  assign busy_o = (state_q != IDLE);
  assign err_o  = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    cfg_ready_o  = 1'b0;
    r_ready_o    = 1'b0;
    addr_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready_o = 1'b1;
        if (cfg_valid_i) state_d = RUN;
      end
      RUN: begin
        addr_valid_o = buf_valid_q;
        r_ready_o    = ~buf_valid_q | (addr_valid_o & addr_ready_i & final_lane);
        if (a_hs && addr_last_o) begin
          // A beat taken on the closing handshake is surplus; its last ends the burst.
          if (buf_last_q || (r_hs && r_last_i)) state_d = IDLE;
          else                                  state_d = DRAIN;
        end
      end
      DRAIN: begin
        r_ready_o = 1'b1;
        if (r_valid_i && r_last_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q      <= '0;
      idx_size_q  <= '0;
      elem_size_q <= '0;
      remaining_q <= '0;
      lane_q      <= '0;
      buf_valid_q <= 1'b0;
      buf_last_q  <= 1'b0;
      buf_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      if (cfg_hs) begin
        base_q      <= cfg_base_i;
        idx_size_q  <= cfg_idx_size_i;
        elem_size_q <= cfg_elem_size_i;
        remaining_q <= cfg_num_i;
        lane_q      <= cfg_offset_i;
        buf_valid_q <= 1'b0;
        err_q       <= 1'b0;
      end
      if (r_hs && r_id_i != IndexId) err_q <= 1'b1;
      if (state_q == RUN) begin
        if (a_hs) begin
          if (remaining_q != '0) remaining_q <= remaining_q - 16'd1;
          lane_q <= final_lane ? '0 : lane_nxt[OffW-1:0];
          if (final_lane || addr_last_o) buf_valid_q <= 1'b0;
          if (early_last) err_q <= 1'b1;
        end
        if (r_hs && !(a_hs && addr_last_o)) begin
          buf_valid_q <= 1'b1;
          buf_data_q  <= r_data_i;
          buf_last_q  <= r_last_i;
        end
      end
    end
  end

endmodule
